eip_sequencer: RTL
==================

Name: eip_sequencer

Overview:
- Owns the architectural EIP register for Tiny86 and sequences every EIP update, one instruction per handshake.
- Evaluates Jcc/JCXZ conditions from EFLAGS/ECX and selects sequential, relative, absolute or indirect targets.
- For register/memory-indirect transfers (CALLr, JMPr, RET) it waits for a late-arriving target before retiring.
- Sits between decode (opc, length, displacement) and fetch (consumes eip/eip_valid).

Parameters:
RESET_EIP, 32'h0000_0000, EIP value loaded on reset
MAX_INSTR_LEN, 15, largest legal instr_len; larger or zero is a length fault

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  decoded instruction present
in_ready  output  1  sequencer can accept an instruction this cycle
opc  input  7  command index (CMD_* encoding)
instr_len  input  4  byte length of the instruction
address  input  32  relative displacement, or absolute target for CALLi/JMPi
eflags  input  32  current flags (CF b0, PF b2, ZF b6, SF b7, OF b11)
ecx  input  32  current ECX, used by JCXZ
tgt_valid  input  1  indirect target valid (CALLr/JMPr/RET)
tgt  input  32  indirect target value
halt_req  input  1  request to stop sequencing
eip  output  32  current EIP (fetch address)
eip_valid  output  1  eip is architecturally settled
retired  output  1  one-cycle pulse when eip was updated by an instruction
taken  output  1  one-cycle pulse, qualifies retired: transfer taken
halted  output  1  sticky, HALT state
fault  output  1  sticky, FAULT state

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-WAIT_TGT):
  - eip=RESET_EIP; state=RUN; in_ready=1; eip_valid=1.
  - retired=0, taken=0, halted=0, fault=0.
- States: RUN, WAIT_TGT, HALT, FAULT. in_ready=1 and eip_valid=1 only in RUN.
- Accept = in_valid & in_ready. Outputs are registered: eip updates, and retired/taken pulse, on the edge after accept (latency 1).
- Width rules:
  - seq = eip + zero-extended instr_len, mod 2^32.
  - Relative target = seq + address, mod 2^32; wrap is silent.
- Length check on accept: instr_len==0 or instr_len>MAX_INSTR_LEN -> FAULT; eip unchanged, no retired pulse, fault=1.
- Condition evaluation:
  - JO OF; JNO !OF; JB CF; JAE !CF; JE ZF; JNE !ZF.
  - JBE CF|ZF; JA !CF&!ZF; JS SF; JNS !SF; JP PF; JNP !PF.
  - JL SF^OF; JNL !(SF^OF); JLE ZF|(SF^OF); JG !ZF&!(SF^OF).
  - JCXZ: ecx==0.
- Next-EIP selection on accept:
  - Jcc/JCXZ: taken -> relative target, taken=1; not taken -> seq, taken=0.
  - CALLi/JMPi: address, taken=1.
  - CALLr/JMPr/RET:
    - tgt_valid same cycle -> eip=tgt, taken=1.
    - Otherwise -> WAIT_TGT; eip held, eip_valid=0, no pulse.
  - Any other opc: seq, taken=0.
- WAIT_TGT: on tgt_valid, eip=tgt, retired=taken=1, return to RUN (or HALT if halt pending). in_valid is ignored.
- halt_req:
  - RUN with no accept -> HALT next edge.
  - RUN with accept -> the instruction retires normally, then HALT.
  - During WAIT_TGT, latched as pending and honoured after the target resolves.
- HALT and FAULT: sticky until rst; eip frozen; in_ready=0, eip_valid=0.
- FAULT has priority over halt_req on the same edge.
- tgt_valid outside a pending indirect is ignored.

Decomposition:
- CMD_* command indices come from the generated commands package/include.
- A shared defines file holds:
  - EFLAGS bit positions (CF=0, PF=2, ZF=6, SF=7, OF=11).
  - The state encoding (2 bits).
- Sub-module jcc_cond: combinational (opc, eflags, ecx) -> is_jcc, cond_true; reusable by the execute stage.

Test Plan:
- Reset then NOP (opc not CF, len 3) at eip 0x0 -> after 1 cycle eip=0x3, retired=1, taken=0.
- JE, len 2, address 0xFFFFFFF0, eip 0x100:
  - ZF=1 -> eip=0xF2, taken=1.
  - ZF=0 -> eip=0x102, taken=0.
- JMPi address 0x8000_0000 from eip 0x10 -> eip=0x8000_0000, taken=1.
- Relative wrap: eip 0xFFFF_FFFE, JMPr-free JG with len 4, SF=OF=0, ZF=0, address 0x10 -> eip=0x12.
- RET with tgt_valid=0 for 3 cycles then tgt=0x4000:
  - During the wait: in_ready=0, eip_valid=0, eip held.
  - On resolve: eip=0x4000, retired=1.
  - halt_req asserted mid-wait -> halted=1 on the following cycle.
- Fault and reset recovery: instr_len=0 accepted -> fault=1, eip unchanged, in_ready=0; rst during FAULT -> eip=RESET_EIP, fault=0.

Source files
------------

// File: rtl/eip_sequencer_pkg.sv
// Shared definitions for the Tiny86 EIP sequencer.
//  - CMD_* command indices used by decode for control-transfer instructions.
//  - EFLAGS bit positions used by condition evaluation.
//  - 2-bit sequencer state encoding.
//  - Helper predicates classifying commands.
package eip_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_TGT = 2'd1,
      ST_HALT     = 2'd2,
      ST_FAULT    = 2'd3
   } seq_state_t;

   localparam int unsigned FLAG_CF = 0;
   localparam int unsigned FLAG_PF = 2;
   localparam int unsigned FLAG_ZF = 6;
   localparam int unsigned FLAG_SF = 7;
   localparam int unsigned FLAG_OF = 11;

   localparam logic [6:0] CMD_NOP   = 7'd0;
   localparam logic [6:0] CMD_JO    = 7'd1;
   localparam logic [6:0] CMD_JNO   = 7'd2;
   localparam logic [6:0] CMD_JB    = 7'd3;
   localparam logic [6:0] CMD_JAE   = 7'd4;
   localparam logic [6:0] CMD_JE    = 7'd5;
   localparam logic [6:0] CMD_JNE   = 7'd6;
   localparam logic [6:0] CMD_JBE   = 7'd7;
   localparam logic [6:0] CMD_JA    = 7'd8;
   localparam logic [6:0] CMD_JS    = 7'd9;
   localparam logic [6:0] CMD_JNS   = 7'd10;
   localparam logic [6:0] CMD_JP    = 7'd11;
   localparam logic [6:0] CMD_JNP   = 7'd12;
   localparam logic [6:0] CMD_JL    = 7'd13;
   localparam logic [6:0] CMD_JNL   = 7'd14;
   localparam logic [6:0] CMD_JLE   = 7'd15;
   localparam logic [6:0] CMD_JG    = 7'd16;
   localparam logic [6:0] CMD_JCXZ  = 7'd17;
   localparam logic [6:0] CMD_CALLI = 7'd18;
   localparam logic [6:0] CMD_JMPI  = 7'd19;
   localparam logic [6:0] CMD_CALLR = 7'd20;
   localparam logic [6:0] CMD_JMPR  = 7'd21;
   localparam logic [6:0] CMD_RET   = 7'd22;

   // Transfers whose target arrives late from the register file / memory.
   function automatic logic is_indirect(input logic [6:0] op);
      return (op == CMD_CALLR) || (op == CMD_JMPR) || (op == CMD_RET);
   endfunction

   // Transfers whose target is carried verbatim in the address field.
   function automatic logic is_absolute(input logic [6:0] op);
      return (op == CMD_CALLI) || (op == CMD_JMPI);
   endfunction

endpackage

// File: rtl/eip_sequencer_jcc_cond.sv
// Combinational Jcc/JCXZ condition evaluator.
// Ports:
//   opc       in  command index
//   eflags    in  current flags
//   ecx       in  current ECX (JCXZ)
//   is_jcc    out opc is a conditional branch (Jcc or JCXZ)
//   cond_true out branch condition holds (meaningful only when is_jcc)
module jcc_cond
   import eip_sequencer_pkg::*;
(
   input  logic [6:0]  opc,
   input  logic [31:0] eflags,
   input  logic [31:0] ecx,
   output logic        is_jcc,
   output logic        cond_true
);

   logic cf, pf, zf, sf, of_f, lt;
   logic unused_flags;

   assign cf   = eflags[FLAG_CF];
   assign pf   = eflags[FLAG_PF];
   assign zf   = eflags[FLAG_ZF];
   assign sf   = eflags[FLAG_SF];
   assign of_f = eflags[FLAG_OF];
   // Signed less-than.
   assign lt   = sf ^ of_f;
   assign unused_flags = ^{eflags[31:12], eflags[10:8], eflags[5:3], eflags[1]};

   always_comb begin
      is_jcc    = 1'b1;
      cond_true = 1'b0;
      case (opc)
         CMD_JO:   cond_true = of_f;
         CMD_JNO:  cond_true = !of_f;
         CMD_JB:   cond_true = cf;
         CMD_JAE:  cond_true = !cf;
         CMD_JE:   cond_true = zf;
         CMD_JNE:  cond_true = !zf;
         CMD_JBE:  cond_true = cf | zf;
         CMD_JA:   cond_true = !cf & !zf;
         CMD_JS:   cond_true = sf;
         CMD_JNS:  cond_true = !sf;
         CMD_JP:   cond_true = pf;
         CMD_JNP:  cond_true = !pf;
         CMD_JL:   cond_true = lt;
         CMD_JNL:  cond_true = !lt;
         CMD_JLE:  cond_true = zf | lt;
         CMD_JG:   cond_true = !zf & !lt;
         CMD_JCXZ: cond_true = (ecx == 32'd0);
         default:  is_jcc    = 1'b0;
      endcase
   end

endmodule

// File: rtl/eip_sequencer.sv
// Tiny86 EIP sequencer: owns architectural EIP and retires one instruction
// per accepted handshake, selecting sequential / relative / absolute /
// indirect next-EIP. Indirect transfers without a same-cycle target park in
// WAIT_TGT until tgt_valid.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decode handshake
//   opc, instr_len, address  decoded command, length, displacement/target
//   eflags, ecx              condition inputs
//   tgt_valid, tgt           late indirect target
//   halt_req                 stop request
//   eip, eip_valid           fetch address and its validity
//   retired, taken           one-cycle retire pulse, and taken qualifier
//   halted, fault            sticky terminal states
module eip_sequencer
   import eip_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_EIP     = 32'h0000_0000,
   parameter int unsigned MAX_INSTR_LEN = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opc,
   input  logic [3:0]  instr_len,
   input  logic [31:0] address,
   input  logic [31:0] eflags,
   input  logic [31:0] ecx,
   input  logic        tgt_valid,
   input  logic [31:0] tgt,
   input  logic        halt_req,
   output logic [31:0] eip,
   output logic        eip_valid,
   output logic        retired,
   output logic        taken,
   output logic        halted,
   output logic        fault
);

   seq_state_t  state_q, state_d;
   logic [31:0] eip_q, eip_d;
   logic        retired_q, retired_d;
   logic        taken_q, taken_d;
   logic        halt_pend_q, halt_pend_d;

   logic        accept, len_bad, is_jcc, cond_true;
   logic [31:0] seq, rel;

   jcc_cond u_jcc_cond (
      .opc       (opc),
      .eflags    (eflags),
      .ecx       (ecx),
      .is_jcc    (is_jcc),
      .cond_true (cond_true)
   );

   assign accept  = in_valid && (state_q == ST_RUN);
   assign len_bad = (instr_len == 4'd0) || (32'(instr_len) > MAX_INSTR_LEN);
   assign seq     = eip_q + 32'(instr_len);
   assign rel     = seq + address;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         eip_q       <= RESET_EIP;
         retired_q   <= 1'b0;
         taken_q     <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         eip_q       <= eip_d;
         retired_q   <= retired_d;
         taken_q     <= taken_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   // Next state. A halt request arriving with or during an indirect wait is
   // remembered and applied once the target resolves.
   always_comb begin
      state_d     = state_q;
      halt_pend_d = halt_pend_q;
      case (state_q)
         ST_RUN: begin
            if (accept && len_bad) begin
               state_d = ST_FAULT;
            end else if (accept && is_indirect(opc) && !tgt_valid) begin
               state_d     = ST_WAIT_TGT;
               halt_pend_d = halt_req;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end
         end
         ST_WAIT_TGT: begin
            if (tgt_valid) begin
               state_d     = (halt_pend_q || halt_req) ? ST_HALT : ST_RUN;
               halt_pend_d = 1'b0;
            end else begin
               halt_pend_d = halt_pend_q || halt_req;
            end
         end
         default: ;
      endcase
   end

   // Next EIP and retire/taken pulses.
   always_comb begin
      eip_d     = eip_q;
      retired_d = 1'b0;
      taken_d   = 1'b0;
      if (accept && !len_bad) begin
         if (is_jcc) begin
            eip_d     = cond_true ? rel : seq;
            retired_d = 1'b1;
            taken_d   = cond_true;
         end else if (is_absolute(opc)) begin
            eip_d     = address;
            retired_d = 1'b1;
            taken_d   = 1'b1;
         end else if (is_indirect(opc)) begin
            if (tgt_valid) begin
               eip_d     = tgt;
               retired_d = 1'b1;
               taken_d   = 1'b1;
            end
         end else begin
            eip_d     = seq;
            retired_d = 1'b1;
         end
      end else if (state_q == ST_WAIT_TGT && tgt_valid) begin
         eip_d     = tgt;
         retired_d = 1'b1;
         taken_d   = 1'b1;
      end
   end

   assign eip       = eip_q;
   assign in_ready  = (state_q == ST_RUN);
   assign eip_valid = (state_q == ST_RUN);
   assign retired   = retired_q;
   assign taken     = taken_q;
   assign halted    = (state_q == ST_HALT);
   assign fault     = (state_q == ST_FAULT);

endmodule
